// File: rtl/if_fetch_queue_pkg.sv
// rtl/if_fetch_queue_pkg.sv - shared parameters and types for the IF fetch queue
package if_fetch_queue_pkg;

  localparam int FQ_DEPTH = 4;
  localparam int FQ_AW    = 32;
  localparam int FQ_IW    = 32;

  typedef enum logic [1:0] {
    RSP_NONE,
    RSP_DROP,
    RSP_FILL
  } rsp_act_e;

  // Pointer width carries one extra wrap bit so full and empty are distinguishable.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/if_fetch_queue_if.sv
// rtl/if_fetch_queue_if.sv - imem request/response and ID-stage handshake bundle
interface if_fetch_queue_if
  import if_fetch_queue_pkg::*;
#(
  parameter int AW = FQ_AW,
  parameter int IW = FQ_IW
);

  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_gnt;
  logic          imem_rvalid;
  logic [IW-1:0] imem_rdata;
  logic          id_valid;
  logic [AW-1:0] id_pc;
  logic [IW-1:0] id_inst;
  logic          id_ready;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    output id_valid, id_pc, id_inst,
    input  id_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    input  id_valid, id_pc, id_inst,
    output id_ready
  );

endinterface

// File: rtl/if_fetch_queue_fq_entry_array.sv
// rtl/if_fetch_queue_fq_entry_array.sv - DEPTH x {pc, inst, done} storage for the fetch queue
module fq_entry_array
  import if_fetch_queue_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH,
  parameter int AW    = FQ_AW,
  parameter int IW    = FQ_IW
) (
  input  logic                     cpu_clk,
  input  logic                     cpu_rst,
  input  logic                     alloc_en,
  input  logic [$clog2(DEPTH)-1:0] alloc_idx,
  input  logic [AW-1:0]            alloc_pc,
  input  logic                     fill_en,
  input  logic [$clog2(DEPTH)-1:0] fill_idx,
  input  logic [IW-1:0]            fill_inst,
  input  logic                     clear_done,
  input  logic [$clog2(DEPTH)-1:0] head_idx,
  output logic [AW-1:0]            head_pc,
  output logic [IW-1:0]            head_inst,
  output logic                     head_done
);

  logic [AW-1:0]    pc_q   [DEPTH];
  logic [IW-1:0]    inst_q [DEPTH];
  logic [DEPTH-1:0] done_q;

  // Alloc and fill never target the same slot: fill only runs with pend!=0, alloc needs live<DEPTH.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= '0;
        inst_q[i] <= '0;
      end
      done_q <= '0;
    end else begin
      if (clear_done) begin
        done_q <= '0;
      end
      if (alloc_en) begin
        pc_q[alloc_idx]   <= alloc_pc;
        done_q[alloc_idx] <= 1'b0;
      end
      if (fill_en) begin
        inst_q[fill_idx] <= fill_inst;
        done_q[fill_idx] <= 1'b1;
      end
    end
  end

  assign head_pc   = pc_q[head_idx];
  assign head_inst = inst_q[head_idx];
  assign head_done = done_q[head_idx];

endmodule

// File: rtl/if_fetch_queue.sv
// rtl/if_fetch_queue.sv - in-order imem fetch issue and {pc,inst} buffer feeding the ID stage
module if_fetch_queue
  import if_fetch_queue_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH,
  parameter int AW    = FQ_AW,
  parameter int IW    = FQ_IW
) (
  input  logic          cpu_clk,
  input  logic          cpu_rst,
  input  logic [AW-1:0] pc,
  input  logic          pc_valid,
  output logic          fetch_stall,
  input  logic          flush,
  if_fetch_queue_if.master fq
);

  localparam int IXW = $clog2(DEPTH);
  localparam int PW  = ptr_w(DEPTH);

  logic [PW-1:0] head, rsp, tail, drop_cnt;
  logic [PW-1:0] live, pend;
  logic [PW:0]   used;
  logic          credit, issue, pop;
  rsp_act_e      rsp_act;
  logic          head_done;

  assign live = tail - head;
  assign pend = tail - rsp;

  // Responses owed to flushed requests still count against credit until they drain.
  assign used   = {1'b0, live} + {1'b0, drop_cnt};
  assign credit = used < (PW+1)'(DEPTH);

  assign fq.imem_req  = ~cpu_rst & pc_valid & credit & ~flush;
  assign fq.imem_addr = pc;
  assign issue        = fq.imem_req & fq.imem_gnt;
  assign fetch_stall  = ~cpu_rst & pc_valid & ~issue & ~flush;

  assign fq.id_valid = (live != '0) & head_done;
  assign pop         = fq.id_valid & fq.id_ready & ~flush;

  always_comb begin
    rsp_act = RSP_NONE;
    if (fq.imem_rvalid) begin
      if (drop_cnt != '0) begin
        rsp_act = RSP_DROP;
      end else if (pend != '0) begin
        rsp_act = RSP_FILL;
      end
    end
  end

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      head     <= '0;
      rsp      <= '0;
      tail     <= '0;
      drop_cnt <= '0;
    end else if (flush) begin
      // Everything in flight becomes a drop, less the response landing this very cycle.
      head     <= tail;
      rsp      <= tail;
      drop_cnt <= drop_cnt + pend - PW'(rsp_act != RSP_NONE);
    end else begin
      if (issue) begin
        tail <= tail + PW'(1);
      end
      if (pop) begin
        head <= head + PW'(1);
      end
      case (rsp_act)
        RSP_DROP: drop_cnt <= drop_cnt - PW'(1);
        RSP_FILL: rsp      <= rsp + PW'(1);
        default:  ;
      endcase
    end
  end

  fq_entry_array #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .IW    (IW)
  ) u_entries (
    .cpu_clk    (cpu_clk),
    .cpu_rst    (cpu_rst),
    .alloc_en   (issue),
    .alloc_idx  (tail[IXW-1:0]),
    .alloc_pc   (pc),
    .fill_en    ((rsp_act == RSP_FILL) & ~flush),
    .fill_idx   (rsp[IXW-1:0]),
    .fill_inst  (fq.imem_rdata),
    .clear_done (flush),
    .head_idx   (head[IXW-1:0]),
    .head_pc    (fq.id_pc),
    .head_inst  (fq.id_inst),
    .head_done  (head_done)
  );

  a_no_orphan_rsp: assert property (@(posedge cpu_clk) disable iff (cpu_rst)
    !(fq.imem_rvalid && pend == '0 && drop_cnt == '0));

endmodule

// File: tb/tb_if_fetch_queue.sv
// tb/tb_if_fetch_queue.sv - self-checking bench for if_fetch_queue
module tb_if_fetch_queue;
  import if_fetch_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int IW    = 32;
  localparam logic [31:0] PC0 = 32'h1c00_0000;

  typedef struct {
    bit          pv;
    logic [31:0] pc;
    bit          gnt;
    bit          rv;
    logic [31:0] rdata;
    bit          rdy;
    bit          fl;
  } in_t;

  typedef struct {
    in_t         i;
    bit          req;
    bit          stall;
    bit          idv;
    logic [31:0] idpc;
    logic [31:0] idinst;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    bit          done;
  } ent_t;

  logic          cpu_clk = 1'b0;
  logic          cpu_rst = 1'b1;
  logic [AW-1:0] pc = '0;
  logic          pc_valid = 1'b0;
  logic          flush = 1'b0;
  logic          fetch_stall;

  if_fetch_queue_if #(.AW(AW), .IW(IW)) fq();

  if_fetch_queue #(.DEPTH(DEPTH), .AW(AW), .IW(IW)) dut (
    .cpu_clk     (cpu_clk),
    .cpu_rst     (cpu_rst),
    .pc          (pc),
    .pc_valid    (pc_valid),
    .fetch_stall (fetch_stall),
    .flush       (flush),
    .fq          (fq.master)
  );

  always #5 cpu_clk = ~cpu_clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  ent_t mq[$];
  int   mdrop = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int m_out();
    int n = mdrop;
    foreach (mq[i]) if (!mq[i].done) n++;
    return n;
  endfunction

  task automatic drive(input in_t v);
    @(negedge cpu_clk);
    pc_valid        = v.pv;
    pc              = v.pc;
    fq.imem_gnt     = v.gnt;
    fq.imem_rvalid  = v.rv;
    fq.imem_rdata   = v.rdata;
    fq.id_ready     = v.rdy;
    flush           = v.fl;
    #1;
  endtask

  // Queue-level model: live entries in order, plus a count of responses owed to flushed requests.
  task automatic model_step(input in_t v, input string tag, input bit do_chk, output bit issued);
    int p;
    int tot;
    bit credit, ereq, estall, eidv;
    credit = (mq.size() + mdrop) < DEPTH;
    ereq   = v.pv && credit && !v.fl;
    estall = v.pv && !(ereq && v.gnt) && !v.fl;
    eidv   = (mq.size() != 0) && mq[0].done;
    issued = ereq && v.gnt;
    if (do_chk) begin
      chk({tag, "_req"},   64'(fq.imem_req), 64'(ereq));
      chk({tag, "_stall"}, 64'(fetch_stall), 64'(estall));
      chk({tag, "_idv"},   64'(fq.id_valid), 64'(eidv));
      if (ereq) chk({tag, "_addr"}, 64'(fq.imem_addr), 64'(v.pc));
      if (eidv) begin
        chk({tag, "_idpc"},   64'(fq.id_pc),   64'(mq[0].pc));
        chk({tag, "_idinst"}, 64'(fq.id_inst), 64'(mq[0].inst));
      end
    end
    p = 0;
    foreach (mq[i]) if (!mq[i].done) p++;
    if (v.fl) begin
      tot   = mdrop + p;
      mdrop = (v.rv && tot > 0) ? tot - 1 : tot;
      mq.delete();
    end else begin
      if (v.rv) begin
        if (mdrop > 0) begin
          mdrop--;
        end else begin
          for (int i = 0; i < mq.size(); i++) begin
            if (!mq[i].done) begin
              mq[i].inst = v.rdata;
              mq[i].done = 1'b1;
              break;
            end
          end
        end
      end
      if (eidv && v.rdy) void'(mq.pop_front());
      if (issued) mq.push_back('{pc: v.pc, inst: 32'h0, done: 1'b0});
    end
  endtask

  task automatic step_m(input in_t v, input string tag, output bit issued);
    drive(v);
    model_step(v, tag, 1'b1, issued);
  endtask

  task automatic do_reset();
    @(negedge cpu_clk);
    cpu_rst = 1'b1;
    pc_valid = 1'b0; flush = 1'b0;
    fq.imem_gnt = 1'b0; fq.imem_rvalid = 1'b0; fq.imem_rdata = '0; fq.id_ready = 1'b0;
    repeat (2) @(negedge cpu_clk);
    cpu_rst = 1'b0;
    mq.delete();
    mdrop = 0;
  endtask

  function automatic in_t mk(input bit pv, input logic [31:0] pcv, input bit gnt, input bit rv,
                             input logic [31:0] rd, input bit rdy, input bit fl);
    in_t t;
    t.pv = pv; t.pc = pcv; t.gnt = gnt; t.rv = rv; t.rdata = rd; t.rdy = rdy; t.fl = fl;
    return t;
  endfunction

  initial begin
    vec_t        tbl[21];
    in_t         v;
    bit          iss;
    int          cnt;
    logic [31:0] epc;
    logic [31:0] rpc;

    // Reset state, with pc_valid high to show request/stall are held off during reset.
    fq.imem_gnt = 1'b0; fq.imem_rvalid = 1'b0; fq.imem_rdata = '0; fq.id_ready = 1'b0;
    pc_valid = 1'b1; pc = PC0;
    repeat (2) @(negedge cpu_clk);
    #1;
    chk("rst_req",    64'(fq.imem_req),  64'(0));
    chk("rst_stall",  64'(fetch_stall),  64'(0));
    chk("rst_idv",    64'(fq.id_valid),  64'(0));
    chk("rst_idpc",   64'(fq.id_pc),     64'(0));
    chk("rst_idinst", 64'(fq.id_inst),   64'(0));
    do_reset();

    // gnt stall, fill/pop, fill to DEPTH, flush with 4 in flight and drain of the drops.
    tbl[0]  = '{mk(1, PC0,          0, 0, 0,            0, 0), 1, 1, 0, 0, 0};
    tbl[1]  = '{mk(1, PC0,          0, 0, 0,            0, 0), 1, 1, 0, 0, 0};
    tbl[2]  = '{mk(1, PC0,          1, 0, 0,            0, 0), 1, 0, 0, 0, 0};
    tbl[3]  = '{mk(1, PC0 + 4,      1, 1, 32'hA0000000, 0, 0), 1, 0, 0, 0, 0};
    tbl[4]  = '{mk(0, PC0 + 8,      0, 1, 32'hA0000004, 0, 0), 0, 0, 1, PC0, 32'hA0000000};
    tbl[5]  = '{mk(0, PC0 + 8,      0, 0, 0,            1, 0), 0, 0, 1, PC0, 32'hA0000000};
    tbl[6]  = '{mk(0, PC0 + 8,      0, 0, 0,            1, 0), 0, 0, 1, PC0 + 4, 32'hA0000004};
    tbl[7]  = '{mk(0, PC0 + 8,      0, 0, 0,            1, 0), 0, 0, 0, 0, 0};
    tbl[8]  = '{mk(1, PC0 + 32'h10, 1, 0, 0,            0, 0), 1, 0, 0, 0, 0};
    tbl[9]  = '{mk(1, PC0 + 32'h14, 1, 0, 0,            0, 0), 1, 0, 0, 0, 0};
    tbl[10] = '{mk(1, PC0 + 32'h18, 1, 0, 0,            0, 0), 1, 0, 0, 0, 0};
    tbl[11] = '{mk(1, PC0 + 32'h1c, 1, 0, 0,            0, 0), 1, 0, 0, 0, 0};
    tbl[12] = '{mk(1, PC0 + 32'h20, 1, 0, 0,            0, 0), 0, 1, 0, 0, 0};
    tbl[13] = '{mk(1, PC0 + 32'h20, 1, 0, 0,            0, 1), 0, 0, 0, 0, 0};
    tbl[14] = '{mk(1, PC0 + 32'h100,1, 1, 32'hDEAD0000, 0, 0), 0, 1, 0, 0, 0};
    tbl[15] = '{mk(1, PC0 + 32'h100,1, 1, 32'hDEAD0001, 0, 0), 1, 0, 0, 0, 0};
    tbl[16] = '{mk(0, PC0 + 32'h104,0, 1, 32'hDEAD0002, 0, 0), 0, 0, 0, 0, 0};
    tbl[17] = '{mk(0, PC0 + 32'h104,0, 1, 32'hDEAD0003, 0, 0), 0, 0, 0, 0, 0};
    tbl[18] = '{mk(0, PC0 + 32'h104,0, 1, 32'hB0000100, 0, 0), 0, 0, 0, 0, 0};
    tbl[19] = '{mk(0, PC0 + 32'h104,0, 0, 0,            1, 0), 0, 0, 1, PC0 + 32'h100, 32'hB0000100};
    tbl[20] = '{mk(0, PC0 + 32'h104,0, 0, 0,            0, 0), 0, 0, 0, 0, 0};

    for (int k = 0; k < 21; k++) begin
      drive(tbl[k].i);
      chk($sformatf("tbl%0d_req", k),   64'(fq.imem_req), 64'(tbl[k].req));
      chk($sformatf("tbl%0d_stall", k), 64'(fetch_stall), 64'(tbl[k].stall));
      chk($sformatf("tbl%0d_idv", k),   64'(fq.id_valid), 64'(tbl[k].idv));
      if (tbl[k].req) chk($sformatf("tbl%0d_addr", k), 64'(fq.imem_addr), 64'(tbl[k].i.pc));
      if (tbl[k].idv) begin
        chk($sformatf("tbl%0d_idpc", k),   64'(fq.id_pc),   64'(tbl[k].idpc));
        chk($sformatf("tbl%0d_idinst", k), 64'(fq.id_inst), 64'(tbl[k].idinst));
      end
      model_step(tbl[k].i, "tbl", 1'b0, iss);
    end

    // Streaming: one delivery per cycle from the third cycle on, never stalled.
    do_reset();
    cnt = 0; epc = PC0; rpc = PC0;
    for (int k = 0; k < 10; k++) begin
      v = mk(1, rpc, 1, m_out() > 0, 32'hC0000000 + 32'(k), 1, 0);
      step_m(v, "stream", iss);
      chk("stream_nostall", 64'(fetch_stall), 64'(0));
      if (fq.id_valid) begin
        chk("stream_seq", 64'(fq.id_pc), 64'(epc));
        epc += 4;
        cnt++;
      end
      if (iss) rpc += 4;
    end
    chk("stream_count", 64'(cnt), 64'(8));

    // Flush with pend=3 and a response in the same cycle: two drops remain, limiting credit to 2.
    do_reset();
    for (int k = 0; k < 3; k++) step_m(mk(1, PC0 + 32'h200 + 32'(4*k), 1, 0, 0, 0, 0), "f3", iss);
    step_m(mk(1, PC0 + 32'h20c, 1, 1, 32'hDEAD1000, 0, 1), "f3fl", iss);
    cnt = 0;
    for (int k = 0; k < 3; k++) begin
      step_m(mk(1, PC0 + 32'h300 + 32'(4*cnt), 1, 0, 0, 0, 0), "f3iss", iss);
      if (iss) cnt++;
    end
    chk("f3_credit_grants", 64'(cnt), 64'(2));
    step_m(mk(0, 0, 0, 1, 32'hDEAD1001, 1, 0), "f3d1", iss);
    step_m(mk(0, 0, 0, 1, 32'hDEAD1002, 1, 0), "f3d2", iss);
    step_m(mk(0, 0, 0, 1, 32'hAAAA0001, 0, 0), "f3f", iss);
    step_m(mk(0, 0, 0, 0, 0, 0, 0), "f3out", iss);
    chk("f3_idv",    64'(fq.id_valid), 64'(1));
    chk("f3_idpc",   64'(fq.id_pc),    64'(PC0 + 32'h300));
    chk("f3_idinst", 64'(fq.id_inst),  64'(32'hAAAA0001));

    // Asynchronous reset mid-burst: outputs drop without a clock, late response is ignored.
    do_reset();
    for (int k = 0; k < 3; k++) step_m(mk(1, PC0 + 32'h400 + 32'(4*k), 1, k > 0, 32'hE0 + 32'(k), 0, 0), "ar", iss);
    drive(mk(1, PC0 + 32'h40c, 1, 0, 0, 0, 0));
    #1 cpu_rst = 1'b1;
    #1;
    chk("ar_idv",   64'(fq.id_valid), 64'(0));
    chk("ar_req",   64'(fq.imem_req), 64'(0));
    chk("ar_stall", 64'(fetch_stall), 64'(0));
    @(negedge cpu_clk);
    fq.imem_rvalid = 1'b1; fq.imem_rdata = 32'hBAD0BAD0;
    @(negedge cpu_clk);
    fq.imem_rvalid = 1'b0; pc_valid = 1'b0;
    cpu_rst = 1'b0;
    mq.delete(); mdrop = 0;
    for (int k = 0; k < 3; k++) step_m(mk(0, 0, 0, 0, 0, 1, 0), "arpost", iss);

    // Randomized traffic against the queue model.
    rpc = PC0;
    for (int k = 0; k < 1500; k++) begin
      v.pv    = $urandom_range(0, 9) < 8;
      v.pc    = rpc;
      v.gnt   = $urandom_range(0, 9) < 7;
      v.fl    = $urandom_range(0, 39) == 0;
      v.rv    = (m_out() > 0) && ($urandom_range(0, 1) == 1);
      v.rdata = $urandom;
      v.rdy   = $urandom_range(0, 9) < 7;
      step_m(v, "rnd", iss);
      if (v.fl) rpc = {$urandom} & 32'hFFFF_FFFC;
      else if (iss) rpc += 4;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
